// File: rtl/return_stack_ctrl_pkg.sv
// Shared sizing defaults and controller state encoding for the return-address stack.
package return_stack_ctrl_pkg;

  localparam int RS_PC_W  = 12;
  localparam int RS_DEPTH = 8;
  localparam int RS_SP_W  = 3;

  // Controller state; ERR freezes the stack until software clears the error.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } rs_state_e;

endpackage

// File: rtl/return_stack_ctrl_regfile.sv
// Stack storage: DEPTH x W array, synchronous write, asynchronous read, no reset.
module stack_regfile #(
  parameter int W     = 14,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack_ctrl.sv
// Return-address stack controller: saves {zero,carry,pc} on call, restores on RET.
module return_stack_ctrl
  import return_stack_ctrl_pkg::*;
#(
  parameter int PC_W  = RS_PC_W,
  parameter int DEPTH = RS_DEPTH,
  parameter int SP_W  = RS_SP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] pc_ret,
  input  logic            zero_in,
  input  logic            carry_in,
  input  logic            err_clr,
  output logic [PC_W-1:0] pc_out,
  output logic            zero_out,
  output logic            carry_out,
  output logic            ret_valid,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            underflow
);

  localparam int EW = PC_W + 2;

  rs_state_e       state_q, state_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            rv_q, rv_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            z_q, z_d;
  logic            c_q, c_d;

  logic            we;
  logic [SP_W-1:0] waddr;
  logic [EW-1:0]   wdata;
  logic [SP_W-1:0] sp_m1;
  logic [EW-1:0]   rdata;
  logic            is_full, is_empty;

  // Reads always target the current top (sp-1); wraps naturally mod DEPTH.
  assign sp_m1    = sp_q - SP_W'(1);
  assign is_full  = (cnt_q == (SP_W+1)'(DEPTH));
  assign is_empty = (cnt_q == '0);

  stack_regfile #(.W(EW), .DEPTH(DEPTH), .AW(SP_W)) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (sp_m1),
    .rdata (rdata)
  );

  // Next-state: stack operations in RUN, frozen in ERR until err_clr.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    rv_d    = 1'b0;
    pc_d    = pc_q;
    z_d     = z_q;
    c_d     = c_q;
    we      = 1'b0;
    waddr   = sp_q;
    wdata   = {zero_in, carry_in, pc_ret};
    unique case (state_q)
      ST_RUN: begin
        if (push && pop) begin
          if (is_empty) begin
            // err_clr wins over a coincident error event
            if (!err_clr) begin
              udf_d   = 1'b1;
              state_d = ST_ERR;
            end
          end else begin
            // Replace top: old top goes out (async read) while new entry lands.
            we                = 1'b1;
            waddr             = sp_m1;
            rv_d              = 1'b1;
            {z_d, c_d, pc_d}  = rdata;
          end
        end else if (push) begin
          if (is_full) begin
            if (!err_clr) begin
              ovf_d   = 1'b1;
              state_d = ST_ERR;
            end
          end else begin
            we    = 1'b1;
            sp_d  = sp_q + SP_W'(1);
            cnt_d = cnt_q + (SP_W+1)'(1);
          end
        end else if (pop) begin
          if (is_empty) begin
            if (!err_clr) begin
              udf_d   = 1'b1;
              state_d = ST_ERR;
            end
          end else begin
            sp_d             = sp_m1;
            cnt_d            = cnt_q - (SP_W+1)'(1);
            rv_d             = 1'b1;
            {z_d, c_d, pc_d} = rdata;
          end
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_RUN;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, pointer, sticky flags and registered restore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rv_q    <= 1'b0;
      pc_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rv_q    <= rv_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign pc_out    = pc_q;
  assign zero_out  = z_q;
  assign carry_out = c_q;
  assign ret_valid = rv_q;
  assign sp        = sp_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Scoreboard bench for return_stack_ctrl against a queue-based stack model.
module tb_return_stack_ctrl;
  import return_stack_ctrl_pkg::*;

  localparam int PC_W  = RS_PC_W;
  localparam int DEPTH = RS_DEPTH;
  localparam int SP_W  = RS_SP_W;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [PC_W-1:0] pc_ret = '0;
  logic            zero_in = 1'b0, carry_in = 1'b0;
  logic [PC_W-1:0] pc_out;
  logic            zero_out, carry_out, ret_valid;
  logic [SP_W-1:0] sp;
  logic            full, empty, overflow, underflow;

  return_stack_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .pc_ret(pc_ret),
    .zero_in(zero_in), .carry_in(carry_in), .err_clr(err_clr),
    .pc_out(pc_out), .zero_out(zero_out), .carry_out(carry_out),
    .ret_valid(ret_valid), .sp(sp), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            z;
    logic            c;
    int              at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: a plain stack of {z,c,pc} plus error status.
  logic [PC_W+1:0] stk[$];
  bit              m_err, m_ovf, m_udf;
  logic [PC_W-1:0] m_pc;
  logic            m_z, m_c;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic void model_reset();
    stk.delete();
    m_err = 0; m_ovf = 0; m_udf = 0;
    m_pc = '0; m_z = 0; m_c = 0;
  endfunction

  function automatic void model_restore(input logic [PC_W+1:0] e);
    exp_t x;
    m_z = e[PC_W+1]; m_c = e[PC_W]; m_pc = e[PC_W-1:0];
    x.pc = m_pc; x.z = m_z; x.c = m_c; x.at = cyc + 1;
    exp_q.push_back(x);
  endfunction

  function automatic void model_step(input logic pu, po, clr,
                                     input logic [PC_W+1:0] e);
    logic [PC_W+1:0] top;
    if (m_err) begin
      if (clr) begin m_err = 0; m_ovf = 0; m_udf = 0; end
    end else if (pu && po) begin
      if (stk.size() == 0) begin
        if (!clr) begin m_err = 1; m_udf = 1; end
      end else begin
        top = stk.pop_back();
        model_restore(top);
        stk.push_back(e);
      end
    end else if (pu) begin
      if (stk.size() == DEPTH) begin
        if (!clr) begin m_err = 1; m_ovf = 1; end
      end else stk.push_back(e);
    end else if (po) begin
      if (stk.size() == 0) begin
        if (!clr) begin m_err = 1; m_udf = 1; end
      end else begin
        top = stk.pop_back();
        model_restore(top);
      end
    end
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".sp"},        int'(sp),        stk.size() % DEPTH);
    chk({tag, ".empty"},     int'(empty),     int'(stk.size() == 0));
    chk({tag, ".full"},      int'(full),      int'(stk.size() == DEPTH));
    chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(m_udf));
    chk({tag, ".pc_out"},    int'(pc_out),    int'(m_pc));
    chk({tag, ".zc_out"},    int'({zero_out, carry_out}), int'({m_z, m_c}));
  endtask

  // One clock of stimulus: drive, update model, advance, check status.
  task automatic step(input string tag, input logic pu, po,
                      input logic [PC_W-1:0] pc, input logic z, c, clr);
    push = pu; pop = po; pc_ret = pc; zero_in = z; carry_in = c; err_clr = clr;
    model_step(pu, po, clr, {z, c, pc});
    @(posedge clk); #1;
    push = 0; pop = 0; err_clr = 0;
    check_status(tag);
  endtask

  // Monitor: every ret_valid pulse must match the oldest expected restore, on time.
  always @(negedge clk) begin
    if (rst) begin
      while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
        checks++; failures++;
        $display("FAIL ret_missing: got no ret_valid expected pc=%0h at cycle %0d", exp_q[0].pc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (ret_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ret_unexpected: got ret_valid pc=%0h expected none (cycle %0d)", pc_out, cyc);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          if (x.at != cyc || pc_out !== x.pc || zero_out !== x.z || carry_out !== x.c) begin
            failures++;
            $display("FAIL ret_data: got pc=%0h z=%0b c=%0b cyc=%0d expected pc=%0h z=%0b c=%0b cyc=%0d",
                     pc_out, zero_out, carry_out, cyc, x.pc, x.z, x.c, x.at);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #1;
    check_status("reset");
    chk("reset.ret_valid", int'(ret_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;

    // 1: push then pop
    step("t1_push", 1, 0, 12'h010, 1, 0, 0);
    step("t1_pop",  0, 1, 12'h000, 0, 0, 0);
    step("t1_idle", 0, 0, 12'h000, 0, 0, 0);

    // 2: fill, then drain in LIFO order
    for (int i = 1; i <= DEPTH; i++) step("t2_push", 1, 0, PC_W'(i), i[0], i[1], 0);
    for (int i = 0; i < DEPTH; i++)  step("t2_pop",  0, 1, '0, 0, 0, 0);

    // 3: overflow, frozen pop, clear, then pop the top
    for (int i = 1; i <= DEPTH; i++) step("t3_push", 1, 0, PC_W'(i), 0, 0, 0);
    step("t3_ovf",   1, 0, 12'h009, 0, 0, 0);
    step("t3_frz",   0, 1, '0, 0, 0, 0);
    step("t3_clr",   0, 0, '0, 0, 0, 1);
    step("t3_pop",   0, 1, '0, 0, 0, 0);
    for (int i = 1; i < DEPTH; i++) step("t3_drain", 0, 1, '0, 0, 0, 0);

    // 4: underflow; clear with a same-cycle push that must be ignored
    step("t4_udf",   0, 1, '0, 0, 0, 0);
    step("t4_clr",   1, 0, 12'h123, 1, 1, 1);
    step("t4_idle",  0, 0, '0, 0, 0, 0);

    // 5: replace top
    step("t5_push",  1, 0, 12'h0A0, 0, 1, 0);
    step("t5_rep",   1, 1, 12'h0B0, 1, 0, 0);
    step("t5_pop",   0, 1, '0, 0, 0, 0);
    step("t5_idle",  0, 0, '0, 0, 0, 0);

    // 6: reset asserted in the middle of a push (with a restore pending)
    step("t6_push",  1, 0, 12'h055, 1, 1, 0);
    push = 1; pop = 1; pc_ret = 12'h3FF; zero_in = 1; carry_in = 1;
    model_step(1, 1, 0, {2'b11, 12'h3FF});
    @(posedge clk); #1;
    push = 1; pop = 0;
    #2 rst = 0;
    #1;
    model_reset();
    exp_q.delete();
    check_status("t6_rst");
    chk("t6_rst.ret_valid", int'(ret_valid), 0);
    @(posedge clk); #1;
    push = 0;
    @(negedge clk) rst = 1;
    step("t6_pop",   0, 1, '0, 0, 0, 0);
    step("t6_clr",   0, 0, '0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic pu, po, cl;
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 7) == 0);
      step("rand", pu, po, PC_W'($urandom), 1'($urandom), 1'($urandom), cl);
    end
    step("end_idle", 0, 0, '0, 0, 0, 0);
    step("end_idle", 0, 0, '0, 0, 0, 0);
    @(negedge clk); #1;
    chk("end.pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
